max_pool_2x2: RTL and testbench
===============================

MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

Interface
REQ-001 SHALL have parameter IN_W, default 30, meaning pixels per input row (conv/ReLU output width); legal values are 2 or more.
REQ-002 SHALL have parameter IN_H, default 30, meaning rows per input frame; legal values are 2 or more.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset: asynchronous, active-low (rst=0 resets).
REQ-005 SHALL have port start_signal  input  1  frame start pulse, sampled only in IDLE.
REQ-006 SHALL have port pixel_valid  input  1  pixel_in is valid this cycle; no backpressure.
REQ-007 SHALL have port pixel_in  input  22  signed ReLU output sample, row-major order.
REQ-008 SHALL have port result_out  output  22  signed pooled maximum, registered.
REQ-009 SHALL have port result_valid  output  1  result_out valid this cycle, one-cycle pulse per result.
REQ-010 SHALL have port done_signal  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 SHALL implement 2x2 max pooling, stride 2: each output = signed max of input pixels (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
REQ-012 SHALL use FSM states IDLE, RUN, DONE; IDLE->RUN on start_signal=1; RUN->DONE on acceptance of pixel (row IN_H-1, col IN_W-1); DONE->IDLE unconditionally after one cycle.
REQ-013 SHALL clear the column counter (0..IN_W-1) and row counter (0..IN_H-1) on the IDLE->RUN transition.
REQ-014 SHALL, in RUN, advance the counters only on pixel_valid=1: col wraps IN_W-1->0 and increments row; gaps of any length are allowed.
REQ-015 SHALL ignore pixel_valid in IDLE and DONE, and ignore start_signal in RUN and DONE.
REQ-016 SHALL, on even col, hold pixel_in in a horizontal register; on odd col, form hmax = signed max(held, pixel_in).
REQ-017 SHALL, on even row with odd col, write hmax into line buffer entry col>>1 (IN_W/2 entries x 22 bits).
REQ-018 SHALL, on odd row with odd col, register result_out = signed max(linebuf[col>>1], hmax) and assert result_valid the next cycle (latency 1 cycle from the 4th contributing pixel).
REQ-019 SHALL use signed comparison on all 22 bits; for ties, either operand may be selected (the value is identical).
REQ-020 SHALL, for odd IN_W or IN_H, drop the trailing column or row, giving floor(IN_W/2)*floor(IN_H/2) outputs per frame.
REQ-021 SHALL hold result_out at its last value when result_valid=0.
REQ-022 SHALL assert done_signal for exactly one cycle, in DONE, which is 2 cycles after the final pixel is accepted (one cycle after the final result_valid for even sizes).
REQ-023 SHALL accept a new start_signal in IDLE the cycle after DONE; the line buffer needs no clearing because each entry is written before it is read.

Reset
REQ-024 SHALL, while rst=0, force FSM=IDLE, counters=0, horizontal register=0, result_out=0, result_valid=0, done_signal=0, asynchronously.
REQ-025 SHALL abandon the current frame if reset occurs mid-frame; after rst returns to 1, no output is produced until a new start_signal.
REQ-026 SHALL leave line buffer contents unspecified after reset (no reset required).

Verification
REQ-027 SHALL cover IN_W=4, IN_H=4: start, then input ramp 0..15 back-to-back -> result_valid pulses carrying 5, 7, 13, 15 in order, then done_signal one cycle after 15.
REQ-028 SHALL cover IN_W=4, IN_H=4 with all pixels -3 except pixel(1,2)=-1 -> outputs -3, -1, -3, -3, checking signed compare.
REQ-029 SHALL cover the ramp with random 0-3 cycle gaps on pixel_valid -> identical outputs; each result_valid 1 cycle after its 4th pixel.
REQ-030 SHALL cover rst=0 for 1 cycle after 6 pixels -> all outputs 0 immediately; pixels with no start produce nothing; a new start followed by the ramp gives 5, 7, 13, 15.
REQ-031 SHALL cover default 30x30 with random nonnegative data -> exactly 225 results matching a reference model, a single done_signal, and start_signal pulses in RUN ignored.
REQ-032 SHALL cover IN_W=5, IN_H=5 ramp 0..24 -> outputs 6, 8, 16, 18; done_signal 2 cycles after pixel 24.

Source files
------------

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 signed max pooling over a row-major frame of IN_W x IN_H pixels.
// Horizontal pairs are reduced on the fly; even-row pair maxima wait in a half-width line buffer.
module max_pool_2x2 #(
    parameter int IN_W = 30,
    parameter int IN_H = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_signal,
    input  logic               pixel_valid,
    input  logic signed [21:0] pixel_in,
    output logic signed [21:0] result_out,
    output logic               result_valid,
    output logic               done_signal
);

    localparam int HALF = IN_W / 2;
    localparam int CW   = ($clog2(IN_W) < 2) ? 2 : $clog2(IN_W);
    localparam int RW   = ($clog2(IN_H) < 1) ? 1 : $clog2(IN_H);
    localparam int AW   = ($clog2(HALF) < 1) ? 1 : $clog2(HALF);

    localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic signed [21:0] hreg;
    logic signed [21:0] hmax;
    logic signed [21:0] vmax;
    logic signed [21:0] lb_rd;
    logic [AW-1:0]      lb_idx;
    logic               accept;
    logic               last_pix;

    logic signed [21:0] linebuf [HALF];

    assign accept   = (state == RUN) && pixel_valid;
    assign last_pix = accept && (col == COL_LAST) && (row == ROW_LAST);
    // Only odd columns address the buffer, so col>>1 always lands below HALF.
    assign lb_idx   = col[AW:1];
    assign lb_rd    = linebuf[lb_idx];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_signal) state_next = RUN;
            RUN:     if (last_pix)     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        hmax = (hreg > pixel_in) ? hreg : pixel_in;
        vmax = (lb_rd > hmax) ? lb_rd : hmax;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col          <= '0;
            row          <= '0;
            hreg         <= '0;
            result_out   <= '0;
            result_valid <= 1'b0;
            done_signal  <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            done_signal  <= (state == DONE);
            if (state == IDLE && start_signal) begin
                col <= '0;
                row <= '0;
            end else if (accept) begin
                if (!col[0]) begin
                    hreg <= pixel_in;
                end else if (row[0]) begin
                    result_out   <= vmax;
                    result_valid <= 1'b1;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // NOTE: the line buffer has no reset; each entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (accept && col[0] && !row[0]) begin
            linebuf[lb_idx] <= hmax;
        end
    end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench for max_pool_2x2: three instances (4x4, 5x5, default 30x30) driven from frame arrays;
// expected maxima and their cycles are queued at stimulus time and popped by a negedge monitor.
module tb_max_pool_2x2;

    localparam int NDUT = 3;

    typedef struct {
        longint val;
        int     cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_v   [NDUT];
    logic               start_v [NDUT];
    logic               pv_v    [NDUT];
    logic signed [21:0] pin_v   [NDUT];
    logic signed [21:0] ro_v    [NDUT];
    logic               rv_v    [NDUT];
    logic               dn_v    [NDUT];

    exp_t               res_q  [NDUT][$];
    int                 done_q [NDUT][$];
    int                 n_res  [NDUT];
    int                 n_done [NDUT];
    logic signed [21:0] frame  [900];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    max_pool_2x2 #(.IN_W(4), .IN_H(4)) dut4 (
        .clk(clk), .rst(rst_v[0]), .start_signal(start_v[0]), .pixel_valid(pv_v[0]),
        .pixel_in(pin_v[0]), .result_out(ro_v[0]), .result_valid(rv_v[0]), .done_signal(dn_v[0])
    );

    max_pool_2x2 #(.IN_W(5), .IN_H(5)) dut5 (
        .clk(clk), .rst(rst_v[1]), .start_signal(start_v[1]), .pixel_valid(pv_v[1]),
        .pixel_in(pin_v[1]), .result_out(ro_v[1]), .result_valid(rv_v[1]), .done_signal(dn_v[1])
    );

    max_pool_2x2 dut30 (
        .clk(clk), .rst(rst_v[2]), .start_signal(start_v[2]), .pixel_valid(pv_v[2]),
        .pixel_in(pin_v[2]), .result_out(ro_v[2]), .result_valid(rv_v[2]), .done_signal(dn_v[2])
    );

    function automatic int w_of(input int d);
        case (d)
            0:       return 4;
            1:       return 5;
            default: return 30;
        endcase
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: every result/done pulse must match the oldest queued expectation, value and cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   dc;
        for (int d = 0; d < NDUT; d++) begin
            if (rv_v[d] === 1'b1) begin
                n_res[d]++;
                if (res_q[d].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut%0d unexpected_result: got %0d, required no result", d, ro_v[d]);
                end else begin
                    e = res_q[d].pop_front();
                    check($sformatf("dut%0d result_value", d), ro_v[d], e.val);
                    check($sformatf("dut%0d result_cycle", d), cyc, e.cyc);
                end
            end
            if (dn_v[d] === 1'b1) begin
                n_done[d]++;
                if (done_q[d].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut%0d unexpected_done: got pulse at cycle %0d, required none", d, cyc);
                end else begin
                    dc = done_q[d].pop_front();
                    check($sformatf("dut%0d done_cycle", d), cyc, dc);
                end
            end
        end
    end

    // Drives one frame from frame[] (row-major, width of DUT d). Stops early after n_pix pixels if n_pix >= 0.
    task automatic run_frame(input int d, input int max_gap, input bit noise, input int n_pix);
        int     w;
        int     h;
        int     cnt;
        longint m;
        w   = w_of(d);
        h   = w;
        cnt = 0;
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (cnt == n_pix) begin
                    pv_v[d]    = 1'b0;
                    start_v[d] = 1'b0;
                    return;
                end
                repeat ($urandom_range(0, max_gap)) begin
                    pv_v[d]    = 1'b0;
                    pin_v[d]   = 22'($urandom);
                    start_v[d] = noise ? 1'($urandom) : 1'b0;
                    @(negedge clk);
                end
                pv_v[d]    = 1'b1;
                pin_v[d]   = frame[y*w + x];
                start_v[d] = noise ? 1'($urandom) : 1'b0;
                if ((y % 2 == 1) && (x % 2 == 1)) begin
                    m = frame[(y-1)*w + x-1];
                    if (frame[(y-1)*w + x] > m) m = frame[(y-1)*w + x];
                    if (frame[y*w + x-1] > m)   m = frame[y*w + x-1];
                    if (frame[y*w + x] > m)     m = frame[y*w + x];
                    res_q[d].push_back('{m, cyc + 1});
                end
                if (y == h-1 && x == w-1) done_q[d].push_back(cyc + 2);
                cnt++;
                @(negedge clk);
            end
        end
        pv_v[d]    = 1'b0;
        start_v[d] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic fill_ramp(input int n);
        for (int i = 0; i < n; i++) frame[i] = 22'(i);
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst_v[d]   = 1'b0;
            start_v[d] = 1'b0;
            pv_v[d]    = 1'b0;
            pin_v[d]   = '0;
            n_res[d]   = 0;
            n_done[d]  = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("dut%0d reset result_out", d), ro_v[d], 0);
            check($sformatf("dut%0d reset result_valid", d), longint'(rv_v[d]), 0);
            check($sformatf("dut%0d reset done_signal", d), longint'(dn_v[d]), 0);
            rst_v[d] = 1'b1;
        end
        @(negedge clk);

        // 4x4 ramp back-to-back: 5, 7, 13, 15
        fill_ramp(16);
        run_frame(0, 0, 1'b0, -1);

        // 4x4 all -3 except (1,2) = -1: -3, -1, -3, -3
        for (int i = 0; i < 16; i++) frame[i] = 22'(-3);
        frame[1*4 + 2] = 22'(-1);
        run_frame(0, 0, 1'b0, -1);

        // 4x4 ramp with 0..3 cycle gaps
        fill_ramp(16);
        run_frame(0, 3, 1'b0, -1);

        // mid-frame reset after 6 pixels (first result 5 already on its way)
        run_frame(0, 0, 1'b0, 6);
        #2 rst_v[0] = 1'b0;
        #1;
        check("dut4 async_reset result_out", ro_v[0], 0);
        check("dut4 async_reset result_valid", longint'(rv_v[0]), 0);
        check("dut4 async_reset done_signal", longint'(dn_v[0]), 0);
        @(negedge clk);
        rst_v[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pv_v[0]  = 1'b1;
            pin_v[0] = frame[i];
            @(negedge clk);
        end
        pv_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        run_frame(0, 0, 1'b0, -1);

        // 5x5 ramp: 6, 8, 16, 18; trailing row/column dropped
        fill_ramp(25);
        run_frame(1, 0, 1'b0, -1);

        // 5x5 full-range signed random data with gaps
        for (int i = 0; i < 25; i++) frame[i] = 22'($urandom);
        run_frame(1, 2, 1'b0, -1);

        // 30x30 random nonnegative data, gaps, start pulses sprinkled through RUN
        for (int i = 0; i < 900; i++) frame[i] = 22'($urandom_range(0, 2097151));
        run_frame(2, 1, 1'b1, -1);

        repeat (10) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("dut%0d results_outstanding", d), res_q[d].size(), 0);
            check($sformatf("dut%0d done_outstanding", d), done_q[d].size(), 0);
        end
        check("dut4 result_count", n_res[0], 17);
        check("dut5 result_count", n_res[1], 8);
        check("dut30 result_count", n_res[2], 225);
        check("dut4 done_count", n_done[0], 4);
        check("dut5 done_count", n_done[1], 2);
        check("dut30 done_count", n_done[2], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
